spi_xfer_sequencer: RTL

- Wishbone master FSM that runs one complete SPI transfer on the SPI core by itself, with no testbench tasks involved.
- On a start pulse it programs DIVIDER, SS and TX0, then writes CTRL with GO=1.
- It polls CTRL until GO clears, then reads RX0 and returns the received word to the local requester.
- It sits between user logic and the SPI core's Wishbone slave port, and replaces the task-driven master in synthesizable designs.

---
 rtl/spi_xfer_sequencer_if.sv | 17 +
 rtl/spi_xfer_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_sequencer_if.sv
// Wishbone master-side bus bundle between the transfer sequencer and the SPI core slave port.
interface spi_xfer_sequencer_if;
  logic [4:0]  adr_o;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_in;
  logic        ack_in;
  logic        err_in;

  modport master (output adr_o, cyc_o, stb_o, we_o, dat_o, sel_o,
                  input  dat_in, ack_in, err_in);
  modport slave  (input  adr_o, cyc_o, stb_o, we_o, dat_o, sel_o,
                  output dat_in, ack_in, err_in);
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Runs one SPI core transfer over Wishbone: program DIVIDER/SS/TX0, set GO, poll CTRL, read RX0.
module spi_xfer_sequencer #(
  parameter int POLL_MAX = 1024,
  parameter int POLL_GAP = 4,
  parameter int SS_W     = 8
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                start_in,
  input  logic [15:0]         div_in,
  input  logic [SS_W-1:0]     ss_in,
  input  logic [31:0]         tx_in,
  input  logic [13:0]         ctrl_in,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic                timeout_o,
  output logic [31:0]         rx_o,
  spi_xfer_sequencer_if.master wb
);

  localparam int PW = $clog2(POLL_MAX + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [PW-1:0] PMAX   = PW'(POLL_MAX);
  localparam logic [GW-1:0] GAP_LD = GW'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    IDLE, WR_DIV, WR_SS, WR_TX, WR_GO, GAP, RD_CTRL, RD_RX, FINISH
  } state_t;

  state_t          state_q, state_d;
  logic            cyc_q, cyc_d, we_q, we_d;
  logic [4:0]      adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [3:0]      sel_q;
  logic            busy_d, done_d, err_d, tout_d;
  logic [31:0]     rx_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            accept, fin;
  logic [15:0]     div_q;
  logic [SS_W-1:0] ss_q;
  logic [31:0]     tx_q;
  logic [13:0]     ctrl_q;
  logic [4:0]      bus_adr;
  logic            bus_we;
  logic [31:0]     bus_dat;

  assign wb.cyc_o = cyc_q;
  assign wb.stb_o = cyc_q;
  assign wb.we_o  = we_q;
  assign wb.adr_o = adr_q;
  assign wb.dat_o = dat_q;
  assign wb.sel_o = sel_q;

  // Register image presented when a bus state opens its cycle.
  always_comb begin
    bus_adr = 5'h00;
    bus_we  = 1'b0;
    bus_dat = '0;
    case (state_q)
      WR_DIV:  begin bus_adr = 5'h14; bus_we = 1'b1; bus_dat = {16'h0, div_q}; end
      WR_SS:   begin bus_adr = 5'h18; bus_we = 1'b1; bus_dat = 32'(ss_q); end
      WR_TX:   begin bus_adr = 5'h00; bus_we = 1'b1; bus_dat = tx_q; end
      WR_GO:   begin bus_adr = 5'h10; bus_we = 1'b1; bus_dat = {18'h0, ctrl_q | 14'h0100}; end
      RD_CTRL: bus_adr = 5'h10;
      default: ;
    endcase
  end

  // Each bus state spends one clock with cyc low before strobing, which keeps cycles separated.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    adr_d   = adr_q;
    we_d    = we_q;
    dat_d   = dat_q;
    busy_d  = busy_o;
    done_d  = 1'b0;
    err_d   = err_o;
    tout_d  = timeout_o;
    rx_d    = rx_o;
    poll_d  = poll_q;
    gap_d   = gap_q;
    accept  = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: if (start_in) begin
        accept  = 1'b1;
        state_d = WR_DIV;
        busy_d  = 1'b1;
        err_d   = 1'b0;
        tout_d  = 1'b0;
        poll_d  = '0;
      end
      GAP: begin
        if (gap_q == '0) state_d = RD_CTRL;
        else             gap_d   = gap_q - 1'b1;
      end
      FINISH: state_d = IDLE;
      default: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          adr_d = bus_adr;
          we_d  = bus_we;
          dat_d = bus_dat;
        end else if (wb.err_in) begin
          cyc_d = 1'b0;
          err_d = 1'b1;
          fin   = 1'b1;
        end else if (wb.ack_in) begin
          cyc_d = 1'b0;
          case (state_q)
            WR_DIV: state_d = WR_SS;
            WR_SS:  state_d = WR_TX;
            WR_TX:  state_d = WR_GO;
            WR_GO:  begin state_d = GAP; gap_d = GAP_LD; end
            RD_CTRL: begin
              if (!wb.dat_in[8]) state_d = RD_RX;
              else begin
                poll_d = poll_q + 1'b1;
                if (poll_d == PMAX) begin tout_d = 1'b1; fin = 1'b1; end
                else begin state_d = GAP; gap_d = GAP_LD; end
              end
            end
            RD_RX: begin rx_d = wb.dat_in; fin = 1'b1; end
            default: ;
          endcase
        end
      end
    endcase
    if (fin) begin
      state_d = FINISH;
      done_d  = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      timeout_o <= 1'b0;
      rx_o      <= '0;
      poll_q    <= '0;
      gap_q     <= '0;
      div_q     <= '0;
      ss_q      <= '0;
      tx_q      <= '0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= {4{cyc_d}};
      busy_o    <= busy_d;
      done_o    <= done_d;
      err_o     <= err_d;
      timeout_o <= tout_d;
      rx_o      <= rx_d;
      poll_q    <= poll_d;
      gap_q     <= gap_d;
      if (accept) begin
        div_q  <= div_in;
        ss_q   <= ss_in;
        tx_q   <= tx_in;
        ctrl_q <= ctrl_in;
      end
    end
  end

endmodule
